// File: rtl/pipeline_pkg.sv
// Shared pipeline types: datapath widths, grouped control bits and the ID/EX
// register image, plus the WB-to-decode bypass selector.
package pipeline_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;
    localparam int REG_W   = 5;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             uses_rs1;
        logic             uses_rs2;
        logic [XLEN-1:0]  rdata1;
        logic [XLEN-1:0]  rdata2;
        logic [XLEN-1:0]  imm;
        ctrl_t            ctrl;
    } id_ex_t;

    localparam id_ex_t BUBBLE_STAGE = '{
        valid:    1'b0,
        pc:       '0,
        rs1:      '0,
        rs2:      '0,
        rd:       '0,
        uses_rs1: 1'b0,
        uses_rs2: 1'b0,
        rdata1:   '0,
        rdata2:   '0,
        imm:      '0,
        ctrl:     BUBBLE_CTRL
    };

    // The register file is read before WB writes it, so a same-cycle WB result wins.
    function automatic logic [XLEN-1:0] bypass_sel(
        input logic             wb_we,
        input logic [REG_W-1:0] wb_rd,
        input logic [REG_W-1:0] rs,
        input logic [XLEN-1:0]  wb_data,
        input logic [XLEN-1:0]  rf_data
    );
        if (wb_we && (wb_rd != '0) && (wb_rd == rs)) return wb_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the valid instruction in ID. Kept standalone for reuse by IF/ID.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic             valid_ex,
    input  logic             mem_read_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             valid_id,
    input  logic             uses_rs1_id,
    input  logic [REG_W-1:0] rs1_id,
    input  logic             uses_rs2_id,
    input  logic [REG_W-1:0] rs2_id,
    output logic             hz
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = uses_rs1_id && (rs1_id == rd_ex);
    assign rs2_match = uses_rs2_id && (rs2_id == rd_ex);

    // x0 is never a real destination, so a load into it cannot create a dependence.
    assign hz = valid_ex && mem_read_ex && (rd_ex != '0) && valid_id && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush bubbles and
// WB-to-decode bypass. Optional counters under ID_EX_PERF_COUNTERS_EN.
module id_ex_stage #(
    parameter int XLEN    = pipeline_pkg::XLEN,
    parameter int ALUOP_W = pipeline_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_ID,
    input  logic [XLEN-1:0]    pc_ID,
    input  logic [4:0]         rs1_ID,
    input  logic [4:0]         rs2_ID,
    input  logic [4:0]         rd_ID,
    input  logic               uses_rs1_ID,
    input  logic               uses_rs2_ID,
    input  logic [XLEN-1:0]    rdata1_ID,
    input  logic [XLEN-1:0]    rdata2_ID,
    input  logic [XLEN-1:0]    imm_ID,
    input  logic               RegWrite_ID,
    input  logic               MemRead_ID,
    input  logic               MemWrite_ID,
    input  logic               MemtoReg_ID,
    input  logic               ALUSrc_ID,
    input  logic               Branch_ID,
    input  logic               Jump_ID,
    input  logic [ALUOP_W-1:0] ALUOp_ID,
    input  logic               RegWrite_WB,
    input  logic [4:0]         rd_WB,
    input  logic [XLEN-1:0]    wdata_WB,
    input  logic               flush_EX,
    output logic               stall_IF_ID,
    output logic               valid_EX,
    output logic [XLEN-1:0]    pc_EX,
    output logic [4:0]         rs1_EX,
    output logic [4:0]         rs2_EX,
    output logic [4:0]         rd_EX,
    output logic               uses_rs1_EX,
    output logic               uses_rs2_EX,
    output logic [XLEN-1:0]    rdata1_EX,
    output logic [XLEN-1:0]    rdata2_EX,
    output logic [XLEN-1:0]    imm_EX,
    output logic               RegWrite_EX,
    output logic               MemRead_EX,
    output logic               MemWrite_EX,
    output logic               MemtoReg_EX,
    output logic               ALUSrc_EX,
    output logic               Branch_EX,
    output logic               Jump_EX,
    output logic [ALUOP_W-1:0] ALUOp_EX
`ifdef ID_EX_PERF_COUNTERS_EN
    ,
    output logic [31:0]        perf_loaduse_bubbles,
    output logic [31:0]        perf_flush_bubbles
`endif
);

    import pipeline_pkg::*;

    logic   hz;
    id_ex_t stage_d;
    id_ex_t stage_q;

    load_use_detect u_load_use_detect (
        .valid_ex    (stage_q.valid),
        .mem_read_ex (stage_q.ctrl.mem_read),
        .rd_ex       (stage_q.rd),
        .valid_id    (valid_ID),
        .uses_rs1_id (uses_rs1_ID),
        .rs1_id      (rs1_ID),
        .uses_rs2_id (uses_rs2_ID),
        .rs2_id      (rs2_ID),
        .hz          (hz)
    );

    // A redirect kills the stalled instruction anyway, so the stall must not hold it.
    assign stall_IF_ID = hz && !flush_EX;

    always_comb begin
        // NOTE: stage_d gets a full value before any override so every path assigns it and no latch is inferred.
        stage_d = '{
            valid:    valid_ID,
            pc:       pc_ID,
            rs1:      rs1_ID,
            rs2:      rs2_ID,
            rd:       rd_ID,
            uses_rs1: uses_rs1_ID,
            uses_rs2: uses_rs2_ID,
            rdata1:   bypass_sel(RegWrite_WB, rd_WB, rs1_ID, wdata_WB, rdata1_ID),
            rdata2:   bypass_sel(RegWrite_WB, rd_WB, rs2_ID, wdata_WB, rdata2_ID),
            imm:      imm_ID,
            ctrl:     '{reg_write:  RegWrite_ID,
                        mem_read:   MemRead_ID,
                        mem_write:  MemWrite_ID,
                        mem_to_reg: MemtoReg_ID,
                        alu_src:    ALUSrc_ID,
                        branch:     Branch_ID,
                        jump:       Jump_ID,
                        alu_op:     ALUOp_ID}
        };
        if (flush_EX || hz) begin
            stage_d = BUBBLE_STAGE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            stage_q <= BUBBLE_STAGE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_EX    = stage_q.valid;
    assign pc_EX       = stage_q.pc;
    assign rs1_EX      = stage_q.rs1;
    assign rs2_EX      = stage_q.rs2;
    assign rd_EX       = stage_q.rd;
    assign uses_rs1_EX = stage_q.uses_rs1;
    assign uses_rs2_EX = stage_q.uses_rs2;
    assign rdata1_EX   = stage_q.rdata1;
    assign rdata2_EX   = stage_q.rdata2;
    assign imm_EX      = stage_q.imm;
    assign RegWrite_EX = stage_q.ctrl.reg_write;
    assign MemRead_EX  = stage_q.ctrl.mem_read;
    assign MemWrite_EX = stage_q.ctrl.mem_write;
    assign MemtoReg_EX = stage_q.ctrl.mem_to_reg;
    assign ALUSrc_EX   = stage_q.ctrl.alu_src;
    assign Branch_EX   = stage_q.ctrl.branch;
    assign Jump_EX     = stage_q.ctrl.jump;
    assign ALUOp_EX    = stage_q.ctrl.alu_op;

`ifdef ID_EX_PERF_COUNTERS_EN
    logic [31:0] loaduse_cnt_d, loaduse_cnt_q;
    logic [31:0] flush_cnt_d,   flush_cnt_q;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        loaduse_cnt_d = loaduse_cnt_q + 32'(stall_IF_ID);
        flush_cnt_d   = flush_cnt_q + 32'(flush_EX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loaduse_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            loaduse_cnt_q <= loaduse_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign perf_loaduse_bubbles = loaduse_cnt_q;
    assign perf_flush_bubbles   = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and write-back-to-decode bypass.
- Sits directly upstream of the EX-stage forwarding logic and supplies its rs1_EX/rs2_EX operands, register data and control.
- Inserts bubbles on load-use hazards and on EX-resolved branch/jump flushes.
- Drives the stall that freezes the PC and IF/ID.

Parameters:
- XLEN, 32, datapath width (pc, register data, immediate).
- ALUOP_W, 4, ALU operation code width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- valid_ID  in  1  ID holds a real instruction
- pc_ID  in  XLEN  instruction PC
- rs1_ID, rs2_ID, rd_ID  in  5 each  register indices
- uses_rs1_ID, uses_rs2_ID  in  1 each  instruction actually reads rs1/rs2
- rdata1_ID, rdata2_ID  in  XLEN each  register-file read data
- imm_ID  in  XLEN  decoded immediate
- RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID, Jump_ID  in  1 each  control
- ALUOp_ID  in  ALUOP_W  ALU op
- RegWrite_WB  in  1  WB write enable
- rd_WB  in  5  WB destination
- wdata_WB  in  XLEN  WB write data
- flush_EX  in  1  taken branch/jump redirect from EX
- stall_IF_ID  out  1  hold PC and IF/ID this cycle
- valid_EX, pc_EX, rs1_EX, rs2_EX, rd_EX, uses_rs1_EX, uses_rs2_EX, rdata1_EX, rdata2_EX, imm_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX, Jump_EX, ALUOp_EX  out  matching widths  registered EX-stage copies

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: every _EX output is 0, so valid_EX=0 and all control is 0 (a bubble).
- Load-use hazard, combinational:
  - hz = valid_EX & MemRead_EX & (rd_EX!=0) & valid_ID & ((uses_rs1_ID & rs1_ID==rd_EX) | (uses_rs2_ID & rs2_ID==rd_EX)).
- stall_IF_ID = hz & ~flush_EX. It is combinational and deasserts in the same cycle as flush.
- WB bypass, combinational, applied before capture:
  - If RegWrite_WB & rd_WB!=0 & rd_WB==rs1_ID, capture wdata_WB as rdata1_EX; rs2 likewise.
  - Otherwise capture rdata*_ID.
- Register update priority per edge:
  1. rst: bubble.
  2. flush_EX: bubble. ID instruction is discarded; upstream flushes IF/ID itself.
  3. hz: bubble into EX. ID contents are held upstream via stall_IF_ID.
  4. Otherwise: capture all _ID inputs; valid_EX = valid_ID.
- Bubble definition:
  - valid_EX=0.
  - RegWrite/MemRead/MemWrite/Branch/Jump_EX = 0.
  - rd_EX = 0, uses_rs*_EX = 0.
  - Data fields are don't-care, but are zeroed.
- Latency: one cycle ID→EX. A load followed by a dependent instruction costs exactly one bubble; the dependence is then resolved by WB-stage forwarding in EX.
- Boundaries:
  - rd=x0 never causes a stall.
  - valid_ID=0 never stalls.
  - Two back-to-back loads that are not dependent: no stall.
  - A dependent instruction that is still stalled re-evaluates hz each cycle. After one bubble, rd_EX=0, so it advances.
  - rst asserted mid-stall clears stall_IF_ID on the next cycle.

Optional Feature:
- Macro: ID_EX_PERF_COUNTERS_EN.
- When defined, two 32-bit outputs are added, both reset to 0 and wrapping at 2^32:
  - perf_loaduse_bubbles: +1 per edge where hz & ~flush_EX & ~rst.
  - perf_flush_bubbles: +1 per edge where flush_EX & ~rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pipeline_pkg holds:
  - XLEN and ALUOP_W constants.
  - A packed control struct grouping the seven 1-bit controls plus ALUOp.
  - A BUBBLE_CTRL constant.
- Sub-module load_use_detect is combinational and computes hz. It is reusable by a future IF/ID stage.

Test Plan:
- Reset: rst=1 for 2 cycles with random ID inputs → all _EX outputs 0, stall_IF_ID=0.
- Load-use stall:
  - Stimulus: lw x5 in EX (MemRead_EX=1, rd_EX=5), then add x6,x5,x7 in ID (uses_rs1=1).
  - Response: stall_IF_ID=1 for exactly 1 cycle, then a bubble (valid_EX=0), then the add enters EX with rs1_EX=5.
- Flush priority: same hazard as above but flush_EX=1 → stall_IF_ID=0; next cycle valid_EX=0 and RegWrite_EX=0.
- WB bypass:
  - Stimulus: rs1_ID=3, rdata1_ID=0x11, RegWrite_WB=1, rd_WB=3, wdata_WB=0xDEADBEEF → rdata1_EX=0xDEADBEEF.
  - Repeat with rd_WB=0 → rdata1_EX=0x11.
- x0/no-use:
  - lw x0 in EX with ID rs1=0 → no stall.
  - lw x5 in EX with ID rs2=5 but uses_rs2_ID=0 → no stall.
- Counters (ID_EX_PERF_COUNTERS_EN): 3 load-use hazards and 2 flushes → perf_loaduse_bubbles=3, perf_flush_bubbles=2.
